// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch program-counter unit.
// Holds the next-PC source encoding and the request priority encoder.
package fetch_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_RET  = 3'd1,
    SEL_CALL = 3'd2,
    SEL_ABS  = 3'd3,
    SEL_REL  = 3'd4,
    SEL_SEQ  = 3'd5
  } next_sel_e;

  // Highest-priority request wins; everything below it is ignored.
  function automatic next_sel_e pick_next_sel(
    input logic hold,
    input logic stall,
    input logic ret,
    input logic call,
    input logic abs_jump,
    input logic rel_jump
  );
    next_sel_e sel;
    if (hold || stall) sel = SEL_HOLD;
    else if (ret)      sel = SEL_RET;
    else if (call)     sel = SEL_CALL;
    else if (abs_jump) sel = SEL_ABS;
    else if (rel_jump) sel = SEL_REL;
    else               sel = SEL_SEQ;
    return sel;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack: pushes overwrite the oldest entry when full,
// pops are ignored when empty. Entry storage is not reset.
module ret_stack #(
  parameter int unsigned PC_W      = 9,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(RAS_DEPTH));
  assign empty = (count == '0);
  assign top   = mem[wptr - PTR_W'(1)];

  // Pointer and occupancy; a full push advances the pointer over the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      count <= '0;
    end else if (push) begin
      wptr <= wptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      wptr  <= wptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter and fetch control: sequential advance, relative/absolute
// jumps, call/return through ret_stack, sticky halt and per-cycle stall.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W      = 9,
  parameter int unsigned OFF_W     = 15,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             Rel_Jump,
  input  logic [OFF_W-1:0] Offset,
  input  logic             Abs_Jump,
  input  logic [PC_W-1:0]  Target,
  input  logic             Call,
  input  logic             Ret,
  output logic [PC_W-1:0]  PC,
  output logic             Halted,
  output logic             Ras_Overflow,
  output logic             Ras_Underflow
);

  localparam int unsigned SUM_W = (PC_W > OFF_W) ? PC_W : OFF_W;

  next_sel_e       sel;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;
  logic [SUM_W-1:0] off_ext;
  logic [PC_W-1:0] pc_next;
  logic            halted_next;
  logic            ovf_next;
  logic            unf_next;
  logic            ras_push;
  logic            ras_pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_full;
  logic            ras_empty;

  ret_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ret_stack (
    .clk       (CLK),
    .rst_n     (Reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Offset is sign-extended to the wider of the two widths, then the sum wraps to PC_W.
  always_comb begin
    off_ext = SUM_W'($signed(Offset));
    pc_inc  = PC + PC_W'(1);
    pc_rel  = PC_W'(SUM_W'(PC) + off_ext);
  end

  // Next-PC selection; stack and sticky flags only move for the selected request.
  always_comb begin
    pc_next     = PC;
    halted_next = Halted | Halt;
    ovf_next    = Ras_Overflow;
    unf_next    = Ras_Underflow;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    sel         = pick_next_sel(Halted | Halt, Stall, Ret, Call, Abs_Jump, Rel_Jump);
    case (sel)
      SEL_HOLD: pc_next = PC;
      SEL_RET: begin
        if (ras_empty) begin
          pc_next  = pc_inc;
          unf_next = 1'b1;
        end else begin
          pc_next = ras_top;
          ras_pop = 1'b1;
        end
      end
      SEL_CALL: begin
        pc_next  = Target;
        ras_push = 1'b1;
        if (ras_full) ovf_next = 1'b1;
      end
      SEL_ABS:  pc_next = Target;
      SEL_REL:  pc_next = pc_rel;
      SEL_SEQ:  pc_next = pc_inc;
      default:  pc_next = PC;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      PC            <= PC_W'(RESET_PC);
      Halted        <= 1'b0;
      Ras_Overflow  <= 1'b0;
      Ras_Underflow <= 1'b0;
    end else begin
      PC            <= pc_next;
      Halted        <= halted_next;
      Ras_Overflow  <= ovf_next;
      Ras_Underflow <= unf_next;
    end
  end

endmodule
